// File: rtl/jtopl_timer_bank.sv
// jtopl_timer_bank: bank of NCH up-counting interval timers with per-channel
// prescaler, one-shot / auto-reload modes, maskable flags and a shared
// active-low IRQ. Ticks on cenop & zero (the FM op-rate enable).
//
// Optional feature macro: JTOPL_TIMER_CASCADE_EN
//   Defined     -> channel i>0 with cascade[i]=1 steps on overflow[i-1] in the
//                  same cycle; its prescaler is bypassed and held at 0.
//   Not defined -> cascade is ignored, every channel uses its prescaled tick.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   cenop, zero   tick = cenop & zero
//   start_value   NCH*VW   reload value, channel i at [i*VW +: VW]
//   presc         NCH*PSW  prescaler terminal count, channel i at [i*PSW +: PSW]
//   load          NCH      1 = run, 0 = hold at start_value (rearms one-shot)
//   oneshot       NCH      1 = stop after first overflow
//   cascade       NCH      chain channel i to channel i-1 (bit 0 ignored)
//   clr_flag      NCH      clear channel flag (wins over a same-cycle overflow)
//   flagen        NCH      output mask for the flags
//   flag          NCH      pre_flag & flagen
//   overflow      NCH      combinational overflow pulse
//   irq_n         1        ~|flag

// Per-channel state: counter, prescaler, one-shot done bit and raw flag.
// Step/overflow decisions are made in the bank so the cascade ripple stays in
// one combinational process.
module jtopl_timer_ch #(
    parameter int VW  = 8,
    parameter int PSW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           tick,
    input  logic           load,
    input  logic           oneshot,
    input  logic           bypass,
    input  logic           step,
    input  logic           ovf,
    input  logic           clr_flag,
    input  logic [VW-1:0]  start_value,
    input  logic [PSW-1:0] presc,
    output logic [VW-1:0]  cnt,
    output logic           hit,
    output logic           done,
    output logic           pre_flag
);
    logic [PSW-1:0] pcnt;

    // >= rather than == so a lowered presc takes effect on the next tick
    assign hit = (pcnt >= presc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            pcnt <= '0;
            done <= 1'b0;
        end else if (!load) begin
            cnt  <= start_value;
            pcnt <= '0;
            done <= 1'b0;
        end else if (!done) begin
            if (bypass)
                pcnt <= '0;
            else if (tick)
                pcnt <= hit ? '0 : pcnt + 1'b1;
            if (step) begin
                cnt <= ovf ? start_value : cnt + 1'b1;
                if (ovf && oneshot)
                    done <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pre_flag <= 1'b0;
        else if (clr_flag)
            pre_flag <= 1'b0;
        else if (ovf)
            pre_flag <= 1'b1;
    end
endmodule

module jtopl_timer_bank #(
    parameter int NCH = 2,
    parameter int VW  = 8,
    parameter int PSW = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cenop,
    input  logic               zero,
    input  logic [NCH*VW-1:0]  start_value,
    input  logic [NCH*PSW-1:0] presc,
    input  logic [NCH-1:0]     load,
    input  logic [NCH-1:0]     oneshot,
    input  logic [NCH-1:0]     cascade,
    input  logic [NCH-1:0]     clr_flag,
    input  logic [NCH-1:0]     flagen,
    output logic [NCH-1:0]     flag,
    output logic [NCH-1:0]     overflow,
    output logic               irq_n
);
    logic                   tick;
    logic [NCH-1:0][VW-1:0] cnt;
    logic [NCH-1:0]         hit;
    logic [NCH-1:0]         done;
    logic [NCH-1:0]         pre_flag;
    logic [NCH-1:0]         bypass;
    logic [NCH-1:0]         step;
    logic [NCH-1:0]         ovf;

    assign tick = cenop & zero;

`ifdef JTOPL_TIMER_CASCADE_EN
    logic unused_cascade;
    assign unused_cascade = cascade[0];   // channel 0 has no predecessor
`else
    logic unused_cascade;
    assign unused_cascade = ^cascade;
`endif

    // Walk the channels in order so a cascaded channel sees its
    // predecessor's overflow from this same cycle.
    always_comb begin
        logic prev;
        prev     = 1'b0;
        bypass   = '0;
        step     = '0;
        ovf      = '0;
        for (int i = 0; i < NCH; i++) begin
`ifdef JTOPL_TIMER_CASCADE_EN
            bypass[i] = (i > 0) && cascade[i];
`endif
            step[i] = bypass[i] ? prev : (tick & hit[i]);
            ovf[i]  = load[i] & ~done[i] & step[i] & (&cnt[i]);
            prev    = ovf[i];
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        jtopl_timer_ch #(.VW(VW), .PSW(PSW)) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .tick        (tick),
            .load        (load[g]),
            .oneshot     (oneshot[g]),
            .bypass      (bypass[g]),
            .step        (step[g]),
            .ovf         (ovf[g]),
            .clr_flag    (clr_flag[g]),
            .start_value (start_value[g*VW +: VW]),
            .presc       (presc[g*PSW +: PSW]),
            .cnt         (cnt[g]),
            .hit         (hit[g]),
            .done        (done[g]),
            .pre_flag    (pre_flag[g])
        );
    end

    assign overflow = ovf;
    assign flag     = pre_flag & flagen;
    assign irq_n    = ~|flag;
endmodule

// File: tb/tb_jtopl_timer_bank.sv
module tb_jtopl_timer_bank;
    localparam int NCH = 2;
    localparam int VW  = 8;
    localparam int PSW = 4;

    logic               clk = 1'b0;
    logic               clk_run = 1'b1;
    logic               rst_n;
    logic               cenop, zero;
    logic [NCH*VW-1:0]  start_value;
    logic [NCH*PSW-1:0] presc;
    logic [NCH-1:0]     load, oneshot, cascade, clr_flag, flagen;
    logic [NCH-1:0]     flag, overflow;
    logic               irq_n;

    int tests = 0;
    int fails = 0;

    jtopl_timer_bank #(.NCH(NCH), .VW(VW), .PSW(PSW)) dut (
        .clk(clk), .rst_n(rst_n), .cenop(cenop), .zero(zero),
        .start_value(start_value), .presc(presc), .load(load),
        .oneshot(oneshot), .cascade(cascade), .clr_flag(clr_flag),
        .flagen(flagen), .flag(flag), .overflow(overflow), .irq_n(irq_n)
    );

    always #5 if (clk_run) clk = ~clk;

    // Reference model: each channel tracks how many steps remain before it
    // overflows and how many ticks its prescaler has swallowed.
    int             m_left [NCH];
    int             m_pc   [NCH];
    bit             m_done [NCH];
    bit             m_pf   [NCH];
    bit             m_stp  [NCH];
    bit             m_byp  [NCH];
    bit             m_tk;
    logic [NCH-1:0] e_ovf, e_flag;
    logic           e_irq;

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_left[i] = 256; m_pc[i] = 0; m_done[i] = 0; m_pf[i] = 0;
        end
    endtask

    task automatic model_eval();
        bit prev;
        prev = 0;
        m_tk = cenop && zero;
        for (int i = 0; i < NCH; i++) begin
            m_byp[i] = 0;
`ifdef JTOPL_TIMER_CASCADE_EN
            if (i > 0 && cascade[i]) m_byp[i] = 1;
`endif
            m_stp[i] = m_byp[i] ? prev : (m_tk && (m_pc[i] >= int'(presc[i*PSW +: PSW])));
            e_ovf[i] = load[i] && !m_done[i] && m_stp[i] && (m_left[i] == 1);
            prev = e_ovf[i];
            e_flag[i] = m_pf[i] & flagen[i];
        end
        e_irq = (e_flag == '0);
    endtask

    task automatic model_commit();
        for (int i = 0; i < NCH; i++) begin
            int sv, pv;
            sv = int'(start_value[i*VW +: VW]);
            pv = int'(presc[i*PSW +: PSW]);
            if (!load[i]) begin
                m_left[i] = 256 - sv; m_pc[i] = 0; m_done[i] = 0;
            end else if (!m_done[i]) begin
                if (m_byp[i]) m_pc[i] = 0;
                else if (m_tk) m_pc[i] = (m_pc[i] >= pv) ? 0 : m_pc[i] + 1;
                if (m_stp[i]) begin
                    if (e_ovf[i]) begin
                        m_left[i] = 256 - sv;
                        if (oneshot[i]) m_done[i] = 1;
                    end else begin
                        m_left[i] = m_left[i] - 1;
                    end
                end
            end
            if (clr_flag[i]) m_pf[i] = 0;
            else if (e_ovf[i]) m_pf[i] = 1;
        end
    endtask

    // Inputs change at posedge+1; outputs are sampled at the following negedge.
    task automatic settle();
        model_eval();
        @(negedge clk);
    endtask

    task automatic advance();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    // One cycle with every flag cleared and every channel held.
    task automatic idle();
        cenop = 1; zero = 1; load = '0; oneshot = '0; cascade = '0;
        clr_flag = '1; flagen = '0; presc = '0; start_value = '0;
        settle(); advance();
        clr_flag = '0;
    endtask

    task automatic test_reset();
        rst_n = 0; cenop = 0; zero = 0; start_value = '0; presc = '0;
        load = '0; oneshot = '0; cascade = '0; clr_flag = '0; flagen = '1;
        #2;
        tests++;
        if ({overflow, flag, irq_n} !== {2'b00, 2'b00, 1'b1}) begin
            fails++;
            $display("FAIL reset: got ovf=%b flag=%b irq_n=%b want 00 00 1", overflow, flag, irq_n);
        end
        model_reset();
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    task automatic test_basic();
        int first;
        first = -1;
        idle();
        start_value[7:0] = 8'hFE; flagen = 2'b01;
        settle(); advance();
        load = 2'b01;
        for (int k = 0; k < 8; k++) begin
            settle();
            tests++;
            if ({overflow, flag, irq_n} !== {e_ovf, e_flag, e_irq}) begin
                fails++;
                $display("FAIL basic k=%0d: got ovf=%b flag=%b irq_n=%b want %b %b %b",
                         k, overflow, flag, irq_n, e_ovf, e_flag, e_irq);
            end
            if (overflow[0] && first < 0) first = k;
            if (k == 2) begin
                tests++;
                if (flag[0] !== 1'b1 || irq_n !== 1'b0) begin
                    fails++;
                    $display("FAIL basic_flag: got flag=%b irq_n=%b want flag[0]=1 irq_n=0", flag, irq_n);
                end
            end
            advance();
        end
        tests++;
        if (first != 1) begin
            fails++;
            $display("FAIL basic_first: got first overflow at tick %0d want tick 1", first);
        end
    endtask

    task automatic test_presc();
        int n;
        idle();
        start_value[7:0] = 8'hFF; presc[3:0] = 4'd3; flagen = 2'b01;
        settle(); advance();
        load = 2'b01;
        n = 0;
        for (int k = 0; k < 18; k++) begin
            if (k == 14) begin
                tests++;
                if (n != 3) begin
                    fails++;
                    $display("FAIL presc_div4: got %0d overflows in 14 ticks want 3", n);
                end
                n = 0;
                presc[3:0] = 4'd0;
            end
            settle();
            tests++;
            if ({overflow, flag, irq_n} !== {e_ovf, e_flag, e_irq}) begin
                fails++;
                $display("FAIL presc k=%0d: got ovf=%b flag=%b irq_n=%b want %b %b %b",
                         k, overflow, flag, irq_n, e_ovf, e_flag, e_irq);
            end
            n += int'(overflow[0]);
            advance();
        end
        tests++;
        if (n != 4) begin
            fails++;
            $display("FAIL presc_lowered: got %0d overflows in 4 ticks want 4", n);
        end
    endtask

    task automatic test_oneshot();
        int n, at;
        idle();
        start_value[15:8] = 8'hFD; oneshot = 2'b10; flagen = 2'b10;
        settle(); advance();
        load = 2'b10;
        n = 0;
        for (int k = 0; k < 25; k++) begin
            settle();
            tests++;
            if ({overflow, flag, irq_n} !== {e_ovf, e_flag, e_irq}) begin
                fails++;
                $display("FAIL oneshot k=%0d: got ovf=%b flag=%b irq_n=%b want %b %b %b",
                         k, overflow, flag, irq_n, e_ovf, e_flag, e_irq);
            end
            n += int'(overflow[1]);
            advance();
        end
        tests++;
        if (n != 1) begin
            fails++;
            $display("FAIL oneshot_count: got %0d overflows want 1", n);
        end
        load = 2'b00;
        settle(); advance();
        load = 2'b10;
        n = 0; at = -1;
        for (int k = 0; k < 6; k++) begin
            settle();
            if (overflow[1]) begin n++; at = k; end
            advance();
        end
        tests++;
        if (n != 1 || at != 2) begin
            fails++;
            $display("FAIL oneshot_rearm: got %0d overflows last at %0d want 1 at 2", n, at);
        end
    endtask

    task automatic test_flag();
        idle();
        start_value[7:0] = 8'hFE; flagen = 2'b01;
        settle(); advance();
        load = 2'b01;
        for (int k = 0; k < 6; k++) begin
            clr_flag = 2'b00;
            model_eval();
            if (e_ovf[0]) clr_flag = 2'b01;
            settle();
            tests++;
            if ({overflow, flag, irq_n} !== {e_ovf, e_flag, e_irq} || flag[0] !== 1'b0) begin
                fails++;
                $display("FAIL flag_clr k=%0d: got ovf=%b flag=%b irq_n=%b want %b 00 1",
                         k, overflow, flag, irq_n, e_ovf);
            end
            advance();
        end
        clr_flag = 2'b00; flagen = 2'b00;
        for (int k = 0; k < 4; k++) begin
            settle();
            tests++;
            if ({overflow, flag, irq_n} !== {e_ovf, e_flag, e_irq}) begin
                fails++;
                $display("FAIL flag_mask k=%0d: got ovf=%b flag=%b irq_n=%b want %b %b %b",
                         k, overflow, flag, irq_n, e_ovf, e_flag, e_irq);
            end
            advance();
        end
        flagen = 2'b01;
        #1;
        tests++;
        if (flag[0] !== 1'b1 || irq_n !== 1'b0) begin
            fails++;
            $display("FAIL flag_unmask: got flag=%b irq_n=%b want flag[0]=1 irq_n=0", flag, irq_n);
        end
    endtask

    task automatic test_cascade();
        int n0, n1;
        idle();
        start_value = {8'hFE, 8'hFF}; presc = {4'd0, 4'd1}; cascade = 2'b10; flagen = 2'b11;
        settle(); advance();
        load = 2'b11;
        n0 = 0; n1 = 0;
        for (int k = 0; k < 16; k++) begin
            settle();
            tests++;
            if ({overflow, flag, irq_n} !== {e_ovf, e_flag, e_irq}) begin
                fails++;
                $display("FAIL cascade k=%0d: got ovf=%b flag=%b irq_n=%b want %b %b %b",
                         k, overflow, flag, irq_n, e_ovf, e_flag, e_irq);
            end
            n0 += int'(overflow[0]);
            n1 += int'(overflow[1]);
            advance();
        end
        tests++;
`ifdef JTOPL_TIMER_CASCADE_EN
        if (n0 != 8 || n1 != 4) begin
`else
        if (n0 != 8 || n1 != 8) begin
`endif
            fails++;
            $display("FAIL cascade_count: got ch0=%0d ch1=%0d overflows", n0, n1);
        end
    endtask

    task automatic test_async_reset();
        int first;
        idle();
        start_value[7:0] = 8'hFE; flagen = 2'b01;
        settle(); advance();
        load = 2'b01;
        for (int k = 0; k < 3; k++) begin settle(); advance(); end
        clk_run = 0;
        #2 rst_n = 0;
        #1;
        tests++;
        if ({overflow, flag, irq_n} !== {2'b00, 2'b00, 1'b1}) begin
            fails++;
            $display("FAIL async_reset: got ovf=%b flag=%b irq_n=%b want 00 00 1", overflow, flag, irq_n);
        end
        model_reset();
        load = 2'b00;
        #10 rst_n = 1;
        #3 clk_run = 1;
        settle(); advance();
        load = 2'b01;
        first = -1;
        for (int k = 0; k < 5; k++) begin
            settle();
            if (overflow[0] && first < 0) first = k;
            advance();
        end
        tests++;
        if (first != 1) begin
            fails++;
            $display("FAIL reset_restart: got first overflow at tick %0d want tick 1", first);
        end
    endtask

    task automatic test_random();
        idle();
        for (int k = 0; k < 400; k++) begin
            cenop = ($urandom_range(0, 3) != 0);
            zero  = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NCH; i++) begin
                start_value[i*VW +: VW] = 8'hF8 + 8'($urandom_range(0, 7));
                presc[i*PSW +: PSW]     = 4'($urandom_range(0, 2));
                load[i]     = ($urandom_range(0, 19) != 0);
                oneshot[i]  = ($urandom_range(0, 3) == 0);
                clr_flag[i] = ($urandom_range(0, 9) == 0);
                flagen[i]   = ($urandom_range(0, 3) != 0);
                cascade[i]  = ($urandom_range(0, 1) != 0);
            end
            settle();
            tests++;
            if ({overflow, flag, irq_n} !== {e_ovf, e_flag, e_irq}) begin
                fails++;
                $display("FAIL random k=%0d: got ovf=%b flag=%b irq_n=%b want %b %b %b",
                         k, overflow, flag, irq_n, e_ovf, e_flag, e_irq);
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_presc();
        test_oneshot();
        test_flag();
        test_cascade();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
